// File: rtl/vga_plot_writer.sv
// Frame-buffer writer: clears the screen, then plots incoming points as pixel writes.
// Optional macro PLOT_ERASE_EN adds per-column history so each new point first erases the old one.
module vga_plot_writer #(
  parameter int          WIDTH       = 160,
  parameter int          HEIGHT      = 120,
  parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_y,
  input  logic [11:0] in_color,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [14:0] fb_addr,
  output logic [11:0] fb_data,
  output logic        fb_wren,
  output logic        busy,
  output logic        clear_done,
  output logic [7:0]  drop_count
);

  localparam logic [14:0] LAST_ADDR = 15'(WIDTH * HEIGHT - 1);
  localparam logic [14:0] WIDTH_15  = 15'(WIDTH);
  localparam logic [8:0]  WIDTH_9   = 9'(WIDTH);
  localparam logic [8:0]  HEIGHT_9  = 9'(HEIGHT);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    PLOT
`ifdef PLOT_ERASE_EN
    , ERASE
`endif
  } state_t;

  state_t state;

  // Row-major pixel address; the 160-wide screen uses shift-and-add instead of a multiplier.
  function automatic logic [14:0] pixel_addr(input logic [7:0] y, input logic [7:0] x);
    logic [14:0] yw;
    logic [14:0] xw;
    yw = {7'b0, y};
    xw = {7'b0, x};
    if (WIDTH == 160) return (yw << 7) + (yw << 5) + xw;
    else              return yw * WIDTH_15 + xw;
  endfunction

  logic point_ok;
  assign point_ok = ({1'b0, in_x} < WIDTH_9) && ({1'b0, in_y} < HEIGHT_9);

  assign in_ready = (state == PLOT) && !start;
  assign busy     = (state == CLEAR);

`ifdef PLOT_ERASE_EN
  logic [7:0]       hist_y [WIDTH];
  logic [WIDTH-1:0] hist_v;
  logic [14:0]      pend_addr;
  logic [11:0]      pend_color;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fb_wren    <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      clear_done <= 1'b0;
      drop_count <= '0;
`ifdef PLOT_ERASE_EN
      hist_v     <= '0;
      pend_addr  <= '0;
      pend_color <= '0;
`endif
    end else begin
      fb_wren    <= 1'b0;
      clear_done <= 1'b0;
      // start wins everywhere: any pending plot or erase write is dropped
      if (start) begin
        state   <= CLEAR;
        fb_wren <= 1'b1;
        fb_addr <= '0;
        fb_data <= CLEAR_COLOR;
`ifdef PLOT_ERASE_EN
        hist_v  <= '0;
`endif
      end else begin
        case (state)
          CLEAR: begin
            if (fb_addr == LAST_ADDR) begin
              state      <= PLOT;
              clear_done <= 1'b1;
            end else begin
              fb_wren <= 1'b1;
              fb_addr <= fb_addr + 15'd1;
            end
          end
          PLOT: begin
            if (in_valid) begin
              if (point_ok) begin
                fb_wren <= 1'b1;
`ifdef PLOT_ERASE_EN
                hist_y[in_x] <= in_y;
                hist_v[in_x] <= 1'b1;
                if (hist_v[in_x]) begin
                  fb_addr    <= pixel_addr(hist_y[in_x], in_x);
                  fb_data    <= CLEAR_COLOR;
                  pend_addr  <= pixel_addr(in_y, in_x);
                  pend_color <= in_color;
                  state      <= ERASE;
                end else begin
                  fb_addr <= pixel_addr(in_y, in_x);
                  fb_data <= in_color;
                end
`else
                fb_addr <= pixel_addr(in_y, in_x);
                fb_data <= in_color;
`endif
              end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
              end
            end
          end
`ifdef PLOT_ERASE_EN
          ERASE: begin
            fb_wren <= 1'b1;
            fb_addr <= pend_addr;
            fb_data <= pend_color;
            state   <= PLOT;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_plot_writer.sv
// Directed plus randomized bench for vga_plot_writer, checked against a plain-arithmetic pixel model.
module tb_vga_plot_writer;
  localparam int          W  = 160;
  localparam int          H  = 120;
  localparam logic [11:0] CC = 12'h000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic [11:0] in_color;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] fb_addr;
  logic [11:0] fb_data;
  logic        fb_wren;
  logic        busy;
  logic        clear_done;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  int model_drop = 0;

  vga_plot_writer #(.WIDTH(W), .HEIGHT(H), .CLEAR_COLOR(CC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_y(in_y), .in_color(in_color), .in_valid(in_valid),
    .in_ready(in_ready), .fb_addr(fb_addr), .fb_data(fb_data), .fb_wren(fb_wren),
    .busy(busy), .clear_done(clear_done), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [7:0] x, input logic [7:0] y,
                                input logic [11:0] c);
    in_valid = v;
    in_x     = x;
    in_y     = y;
    in_color = c;
    step();
  endtask

  function automatic int exp_addr(input int x, input int y);
    return y * W + x;
  endfunction

  function automatic bit on_screen(input int x, input int y);
    return (x < W) && (y < H);
  endfunction

  // A whole clear must visit every pixel once, in order, with the background colour
  task automatic run_clear(output int n, output int bad);
    n = 0;
    bad = 0;
    while (busy === 1'b1 && n < 25000) begin
      if (fb_wren !== 1'b1 || fb_addr !== 15'(n) || fb_data !== CC) bad++;
      n++;
      step();
    end
  endtask

  initial begin
    int n, bad, stalls, good_writes;
    logic        v;
    logic [7:0]  x, y;
    logic [11:0] c;

    reset = 1'b1; start = 1'b0;
    in_valid = 1'b0; in_x = '0; in_y = '0; in_color = '0;
    repeat (3) step();
    check_output("reset_wren", fb_wren, 0);
    check_output("reset_addr", fb_addr, 0);
    check_output("reset_data", fb_data, 0);
    check_output("reset_ready", in_ready, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", clear_done, 0);
    check_output("reset_drop", drop_count, 0);

    reset = 1'b0;
    in_valid = 1'b1;
    #1;
    check_output("idle_ready", in_ready, 0);
    step();
    check_output("idle_wren", fb_wren, 0);
    in_valid = 1'b0;

    $display("[TB] full clear");
    start = 1'b1;
    step();
    start = 1'b0;
    run_clear(n, bad);
    check_output("clear_len", n, 19200);
    check_output("clear_order", bad, 0);
    check_output("clear_done_pulse", clear_done, 1);
    check_output("clear_then_ready", in_ready, 1);
    check_output("clear_end_wren", fb_wren, 0);
    step();
    check_output("clear_done_once", clear_done, 0);

    apply_stimulus(1'b1, 8'd5, 8'd10, 12'hFFF);
    in_valid = 1'b0;
    check_output("p5_10_wren", fb_wren, 1);
    check_output("p5_10_addr", fb_addr, exp_addr(5, 10));
    check_output("p5_10_data", fb_data, 12'hFFF);
    step();
    check_output("idle_plot_wren", fb_wren, 0);
    check_output("hold_addr", fb_addr, exp_addr(5, 10));

    apply_stimulus(1'b1, 8'd160, 8'd0, 12'h111);
    check_output("x_oob_wren", fb_wren, 0);
    apply_stimulus(1'b1, 8'd0, 8'd120, 12'h222);
    check_output("y_oob_wren", fb_wren, 0);
    in_valid = 1'b0;
    model_drop = 2;
    check_output("drop_two", drop_count, 2);

    $display("[TB] random points");
    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(0, 3) != 0);
      x = 8'($urandom_range(0, 199));
      y = 8'($urandom_range(0, 149));
      c = 12'($urandom);
      #1;
      check_output("rnd_ready", in_ready, 1);
      apply_stimulus(v, x, y, c);
      if (v && on_screen(x, y)) begin
        check_output("rnd_wren", fb_wren, 1);
        check_output("rnd_addr", fb_addr, exp_addr(x, y));
        check_output("rnd_data", fb_data, c);
      end else begin
        check_output("rnd_nowrite", fb_wren, 0);
        if (v && model_drop < 255) model_drop++;
      end
      check_output("rnd_drop", drop_count, model_drop);
    end
    in_valid = 1'b0;

`ifndef PLOT_ERASE_EN
    $display("[TB] streaming one column per cycle");
    stalls = 0;
    good_writes = 0;
    for (int i = 0; i < W; i++) begin
      in_valid = 1'b1; in_x = 8'(i); in_y = 8'(i % H); in_color = 12'(i * 7);
      #1;
      if (in_ready !== 1'b1) stalls++;
      step();
      if (fb_wren === 1'b1 && fb_addr === 15'(exp_addr(i, i % H)) && fb_data === 12'(i * 7))
        good_writes++;
    end
    in_valid = 1'b0;
    check_output("stream_stalls", stalls, 0);
    check_output("stream_writes", good_writes, W);
`endif

    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1'b1, 8'd200, 8'd0, 12'h000);
      if (model_drop < 255) model_drop++;
    end
    in_valid = 1'b0;
    check_output("drop_sat", drop_count, model_drop);
    check_output("drop_255", drop_count, 255);

    $display("[TB] restart and reset during clear");
    in_valid = 1'b1; in_x = 8'd1; in_y = 8'd1; start = 1'b1;
    #1;
    check_output("start_blocks_ready", in_ready, 0);
    step();
    start = 1'b0; in_valid = 1'b0;
    check_output("plot_start_busy", busy, 1);
    check_output("plot_start_addr", fb_addr, 0);
    check_output("plot_start_data", fb_data, CC);
    repeat (100) step();
    check_output("clear_addr_100", fb_addr, 100);
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("restart_addr", fb_addr, 0);
    repeat (5000) step();
    check_output("clear_addr_5000", fb_addr, 5000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("abort_wren", fb_wren, 0);
    check_output("abort_busy", busy, 0);
    check_output("abort_drop", drop_count, 0);
    step();
    check_output("abort_idle_wren", fb_wren, 0);
    check_output("abort_idle_ready", in_ready, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("reclear_addr", fb_addr, 0);
    run_clear(n, bad);
    check_output("reclear_len", n, 19200);
    check_output("reclear_order", bad, 0);
    check_output("reclear_done", clear_done, 1);

`ifdef PLOT_ERASE_EN
    $display("[TB] column erase");
    apply_stimulus(1'b1, 8'd3, 8'd20, 12'hABC);
    in_valid = 1'b0;
    check_output("er_first_addr", fb_addr, exp_addr(3, 20));
    check_output("er_first_data", fb_data, 12'hABC);
    step();
    apply_stimulus(1'b1, 8'd3, 8'd40, 12'h123);
    in_valid = 1'b0;
    check_output("er_erase_wren", fb_wren, 1);
    check_output("er_erase_addr", fb_addr, exp_addr(3, 20));
    check_output("er_erase_data", fb_data, CC);
    check_output("er_stall", in_ready, 0);
    step();
    check_output("er_new_wren", fb_wren, 1);
    check_output("er_new_addr", fb_addr, exp_addr(3, 40));
    check_output("er_new_data", fb_data, 12'h123);
    check_output("er_ready_back", in_ready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_plot_writer.md
VGA_PLOT_WRITER -- requirements
Module: vga_plot_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 160, visible columns.
REQ-002 SHALL have parameter HEIGHT, default 120, visible rows.
REQ-003 SHALL have parameter CLEAR_COLOR, default 12'h000, background colour.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle pulse; begin a screen clear.
REQ-007 SHALL have port in_x  input  8  point column (sample index from sine stage).
REQ-008 SHALL have port in_y  input  8  point row (sine ROM output).
REQ-009 SHALL have port in_color  input  12  point colour.
REQ-010 SHALL have port in_valid  input  1  point offered.
REQ-011 SHALL have port in_ready  output  1  point accepted when in_valid and in_ready are both high.
REQ-012 SHALL have port fb_addr  output  15  frame-buffer write address.
REQ-013 SHALL have port fb_data  output  12  frame-buffer write data.
REQ-014 SHALL have port fb_wren  output  1  frame-buffer write strobe.
REQ-015 SHALL have port busy  output  1  high in CLEAR.
REQ-016 SHALL have port clear_done  output  1  one-cycle pulse at end of clear.
REQ-017 SHALL have port drop_count  output  8  saturating count of rejected points.

Function
REQ-018 SHALL implement states IDLE, CLEAR, PLOT and, only with ERASE_EN, ERASE.
REQ-019 SHALL go from IDLE to CLEAR on start; in_ready stays low in IDLE.
REQ-020 In CLEAR, SHALL write CLEAR_COLOR to addresses 0 to WIDTH*HEIGHT-1, one per cycle, in ascending order.
REQ-021 With the default parameters, CLEAR SHALL take 19200 cycles.
REQ-022 After the last clear write, SHALL pulse clear_done for one cycle and enter PLOT.
REQ-023 start during CLEAR SHALL restart the clear at address 0.
REQ-024 start during PLOT or ERASE SHALL abandon any pending write and enter CLEAR next cycle.
REQ-025 In PLOT, in_ready SHALL be high unless start is asserted in that cycle.
REQ-026 An accepted point SHALL be valid when in_x < WIDTH and in_y < HEIGHT.
REQ-027 For a valid point accepted in cycle N, SHALL drive fb_wren=1 in cycle N+1, with fb_addr = in_y*WIDTH + in_x and fb_data = in_color.
REQ-028 SHALL compute the address for WIDTH=160 as (y<<7)+(y<<5)+x, without a multiplier.
REQ-029 An invalid accepted point SHALL produce no write and SHALL increment drop_count, which saturates at 255.
REQ-030 SHALL accept back-to-back points, one per cycle, in PLOT without ERASE_EN.
REQ-031 When neither clearing nor plotting, fb_wren SHALL be 0; fb_addr and fb_data hold their last values.
REQ-032 drop_count SHALL clear only on reset.

Reset
REQ-033 On reset, SHALL enter IDLE with fb_wren=0, fb_addr=0, fb_data=0, in_ready=0, busy=0, clear_done=0 and drop_count=0.
REQ-034 Reset mid-clear or mid-erase SHALL abort immediately, with no further writes.
REQ-035 Reset SHALL clear all column-history valid bits.

Configuration
REQ-036 Macro PLOT_ERASE_EN, when defined, SHALL add a WIDTH-entry history of the last plotted y and a valid bit per column.
REQ-037 With PLOT_ERASE_EN defined, a valid point at column x whose history is valid SHALL first write CLEAR_COLOR at the old (y, x) in cycle N+1, then the new point in cycle N+2.
REQ-038 With PLOT_ERASE_EN defined, in_ready SHALL be low during the ERASE cycle, and the history SHALL update to the new y.
REQ-039 With PLOT_ERASE_EN defined, a point whose history is invalid SHALL write directly as in REQ-027 and set the valid bit.
REQ-040 With PLOT_ERASE_EN defined, CLEAR SHALL invalidate all history entries.
REQ-041 Without PLOT_ERASE_EN, SHALL have no history storage and no ERASE state.

Verification
REQ-042 Reset, then start -> busy=1 for 19200 cycles; addresses 0 to 19199 are written with 12'h000; one clear_done pulse; then in_ready=1.
REQ-043 In PLOT, send (x=5, y=10, color=FFF) -> one cycle later fb_wren=1, fb_addr=1605, fb_data=FFF.
REQ-044 Send (x=160, y=0) and then (x=0, y=120) -> no writes, drop_count=2; after 300 invalid points, drop_count=255.
REQ-045 Stream x=0 to 159 with in_valid held high, without ERASE_EN -> 160 consecutive writes with no stall.
REQ-046 With PLOT_ERASE_EN, send (3, 20) then (3, 40) -> writes (3,20)=colour, then (3,20)=CLEAR_COLOR, then (3,40)=colour, with in_ready low for one cycle.
REQ-047 Assert reset at clear address 5000 -> fb_wren=0 on the next cycle and state IDLE; start restarts the clear from 0.
